// File: rtl/jamma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jamma_pkg
// Brief    : Shared types and constants for the JAMMA input scanner.
// Revision : 1.0 - initial release
// ============================================================================
package jamma_pkg;

  // Scan sequencer states: settle then sample, once per player.
  typedef enum logic [1:0] {
    S1_SETTLE = 2'd0,
    S1_SAMPLE = 2'd1,
    S2_SETTLE = 2'd2,
    S2_SAMPLE = 2'd3
  } scan_state_t;

  // Idle (nothing pressed) value of an active-low player word.
  localparam logic [7:0] JOY_IDLE = 8'hFF;

  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_DEB_SAMPLES = 4;

endpackage
`default_nettype wire

// File: rtl/jamma_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : jamma_debounce_bit
// Brief    : Single-bit scan-rate debouncer. The output follows the raw
//            sample only after DEB_SAMPLES consecutive enabled samples
//            disagree with it; any agreeing sample restarts the count.
// Revision : 1.0 - initial release
// ============================================================================
module jamma_debounce_bit #(
  parameter int   DEB_SAMPLES = 4,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic q
);

  logic [3:0] r_cnt;
  logic       r_q;

  // Count disagreeing samples; flip the output on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_q   <= RST_VAL;
    end else if (en) begin
      if (raw == r_q) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == 4'(DEB_SAMPLES - 1)) begin
        r_cnt <= 4'd0;
        r_q   <= raw;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/jamma_input_scanner.sv
`default_nettype none
// ============================================================================
// Module   : jamma_input_scanner
// Brief    : Scans the shared JAMMA bus for two players via jselect, merges
//            the local DB9 joystick into player 1, and turns asynchronous
//            coin switches into one-cycle pulses.
//            Build option: define JAMMA_DEBOUNCE_EN to add per-bit scan-rate
//            debouncing on joy1/joy2 (default: direct raw capture).
// Revision : 1.0 - initial release
// ============================================================================
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int DEB_SAMPLES = DEF_DEB_SAMPLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] jjoy,
  input  logic [5:0] local_joy,
  input  logic [1:0] jcoin,
  output logic       jselect,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic [1:0] coin_pulse,
  output logic       scan_done
);

  // Configurations outside the legal ranges are not supported.
  generate
    if (SETTLE_CYC < 1 || SETTLE_CYC > 255 || DEB_SAMPLES < 2 || DEB_SAMPLES > 15) begin : g_param_range
    end
  endgenerate

  scan_state_t r_state;
  scan_state_t w_state_nxt;
  logic [7:0]  r_settle_cnt;
  logic [7:0]  w_settle_cnt_nxt;
  logic        w_jselect_nxt;
  logic        w_s1_sample;
  logic        w_s2_sample;
  logic [7:0]  w_raw1;
  logic [7:0]  w_raw2;
  logic        r_jselect;
  logic        r_scan_done;

  // State and settle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S1_SETTLE;
      r_settle_cnt <= 8'(SETTLE_CYC);
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
    end
  end

  // Next-state logic: count down the settle time, then sample for one cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    case (r_state)
      S1_SETTLE: begin
        if (r_settle_cnt <= 8'd1) w_state_nxt = S1_SAMPLE;
        else                      w_settle_cnt_nxt = r_settle_cnt - 8'd1;
      end
      S1_SAMPLE: begin
        w_state_nxt      = S2_SETTLE;
        w_settle_cnt_nxt = 8'(SETTLE_CYC);
      end
      S2_SETTLE: begin
        if (r_settle_cnt <= 8'd1) w_state_nxt = S2_SAMPLE;
        else                      w_settle_cnt_nxt = r_settle_cnt - 8'd1;
      end
      S2_SAMPLE: begin
        w_state_nxt      = S1_SETTLE;
        w_settle_cnt_nxt = 8'(SETTLE_CYC);
      end
      default: begin
        w_state_nxt      = S1_SETTLE;
        w_settle_cnt_nxt = 8'(SETTLE_CYC);
      end
    endcase
    w_jselect_nxt = (w_state_nxt == S2_SETTLE) || (w_state_nxt == S2_SAMPLE);
  end

  assign w_s1_sample = (r_state == S1_SAMPLE);
  assign w_s2_sample = (r_state == S2_SAMPLE);
  assign w_raw1      = jjoy & {2'b11, local_joy};
  assign w_raw2      = jjoy;

  // Registered mux select and end-of-scan strobe, both derived from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jselect   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_jselect   <= w_jselect_nxt;
      r_scan_done <= w_s2_sample;
    end
  end

  assign jselect   = r_jselect;
  assign scan_done = r_scan_done;

`ifdef JAMMA_DEBOUNCE_EN
  // One debouncer per player bit, strobed by that player's sample state.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_deb
      jamma_debounce_bit #(
        .DEB_SAMPLES (DEB_SAMPLES),
        .RST_VAL     (JOY_IDLE[i])
      ) u_deb_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_s1_sample),
        .raw   (w_raw1[i]),
        .q     (joy1[i])
      );
      jamma_debounce_bit #(
        .DEB_SAMPLES (DEB_SAMPLES),
        .RST_VAL     (JOY_IDLE[i])
      ) u_deb_p2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_s2_sample),
        .raw   (w_raw2[i]),
        .q     (joy2[i])
      );
    end
  endgenerate
`else
  logic [7:0] r_joy1;
  logic [7:0] r_joy2;

  // Capture each player's word at the end of its sample cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_joy1 <= JOY_IDLE;
      r_joy2 <= JOY_IDLE;
    end else begin
      if (w_s1_sample) r_joy1 <= w_raw1;
      if (w_s2_sample) r_joy2 <= w_raw2;
    end
  end

  assign joy1 = r_joy1;
  assign joy2 = r_joy2;
`endif

  logic [1:0] r_coin_s1;
  logic [1:0] r_coin_s2;
  logic [1:0] r_coin_prev;
  logic [1:0] r_coin_pulse;
  logic [2:0] r_coin_live;

  // Coin synchroniser plus falling-edge detect. r_coin_live marks when the
  // edge-detect flop holds a real sample rather than its reset value, so a
  // coin held low across reset release never looks like a new insertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coin_s1    <= 2'b11;
      r_coin_s2    <= 2'b11;
      r_coin_prev  <= 2'b11;
      r_coin_live  <= 3'b000;
      r_coin_pulse <= 2'b00;
    end else begin
      r_coin_s1    <= jcoin;
      r_coin_s2    <= r_coin_s1;
      r_coin_prev  <= r_coin_s2;
      r_coin_live  <= {r_coin_live[1:0], 1'b1};
      r_coin_pulse <= {2{r_coin_live[2]}} & r_coin_prev & ~r_coin_s2;
    end
  end

  assign coin_pulse = r_coin_pulse;

endmodule
`default_nettype wire

// File: tb/tb_jamma_input_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_jamma_input_scanner
// Brief    : Directed self-checking bench for jamma_input_scanner
//            (SETTLE_CYC=16, DEB_SAMPLES=4). Models the JAMMA bus as a
//            jselect-driven mux between two player words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jamma_input_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] p1;
  logic [7:0] p2;
  logic [7:0] jjoy;
  logic [5:0] local_joy;
  logic [1:0] jcoin;
  logic       jselect;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic [1:0] coin_pulse;
  logic       scan_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External bus mux: cabinet presents the selected player's switches.
  assign jjoy = jselect ? p2 : p1;

  jamma_input_scanner #(
    .SETTLE_CYC  (16),
    .DEB_SAMPLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jjoy       (jjoy),
    .local_joy  (local_joy),
    .jcoin      (jcoin),
    .jselect    (jselect),
    .joy1       (joy1),
    .joy2       (joy2),
    .coin_pulse (coin_pulse),
    .scan_done  (scan_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next scan_done pulse.
  task automatic wait_scan;
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!scan_done && n < 200);
    checks++;
    if (!scan_done) begin
      errors++;
      $display("FAIL scan_timeout: no scan_done after %0d cycles, expected one within 34", n);
    end
  endtask

  task automatic test_reset;
    int rise;
    rst_n = 1'b0; p1 = 8'hFF; p2 = 8'hFF; local_joy = 6'h3F; jcoin = 2'b11;
    repeat (3) tick();
    checks++; if (joy1 !== 8'hFF) begin errors++; $display("FAIL rst_joy1: got %h expected ff", joy1); end
    checks++; if (joy2 !== 8'hFF) begin errors++; $display("FAIL rst_joy2: got %h expected ff", joy2); end
    checks++; if (jselect !== 1'b0) begin errors++; $display("FAIL rst_jselect: got %b expected 0", jselect); end
    checks++; if (coin_pulse !== 2'b00) begin errors++; $display("FAIL rst_coin: got %b expected 00", coin_pulse); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL rst_scan_done: got %b expected 0", scan_done); end
    rst_n = 1'b1;
    rise = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (jselect && rise == 0) rise = i;
    end
    checks++; if (rise != 17) begin errors++; $display("FAIL rst_jselect_rise: got cycle %0d expected 17", rise); end
  endtask

  task automatic test_mux;
    int j1_at, j2_at, sd_at;
    p1 = 8'hFE; p2 = 8'h7F; local_joy = 6'h3D;
    wait_scan();
    wait_scan();
    checks++; if (joy1 !== 8'hFC) begin errors++; $display("FAIL mux_joy1: got %h expected fc", joy1); end
    checks++; if (joy2 !== 8'h7F) begin errors++; $display("FAIL mux_joy2: got %h expected 7f", joy2); end
    p1 = 8'hF0; p2 = 8'h55;
    j1_at = 0; j2_at = 0; sd_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (joy1 !== 8'hFC && j1_at == 0) j1_at = i;
      if (joy2 !== 8'h7F && j2_at == 0) j2_at = i;
      if (scan_done && sd_at == 0) sd_at = i;
    end
    checks++; if (sd_at != 34) begin errors++; $display("FAIL mux_period: scan_done at cycle %0d expected 34", sd_at); end
    checks++; if (j1_at != 17) begin errors++; $display("FAIL mux_joy1_time: changed at cycle %0d expected 17", j1_at); end
    checks++; if (j2_at != 34) begin errors++; $display("FAIL mux_joy2_time: changed at cycle %0d expected 34", j2_at); end
    checks++; if (joy1 !== 8'hF0) begin errors++; $display("FAIL mux_joy1_new: got %h expected f0", joy1); end
    checks++; if (joy2 !== 8'h55) begin errors++; $display("FAIL mux_joy2_new: got %h expected 55", joy2); end
  endtask

  task automatic test_debounce;
    p1 = 8'hFF; p2 = 8'hFF; local_joy = 6'h3F;
    wait_scan();
    p1 = 8'hFE;
    for (int k = 1; k <= 3; k++) begin
      repeat (17) tick();
      checks++; if (joy1 !== 8'hFF) begin errors++; $display("FAIL deb_short_%0d: got %h expected ff", k, joy1); end
      if (k == 3) p1 = 8'hFF;
      wait_scan();
    end
    wait_scan();
    checks++; if (joy1 !== 8'hFF) begin errors++; $display("FAIL deb_short_end: got %h expected ff", joy1); end
    p1 = 8'hFE;
    for (int k = 1; k <= 4; k++) begin
      repeat (17) tick();
      if (k < 4) begin
        checks++; if (joy1 !== 8'hFF) begin errors++; $display("FAIL deb_long_%0d: got %h expected ff", k, joy1); end
      end else begin
        checks++; if (joy1 !== 8'hFE) begin errors++; $display("FAIL deb_long_4: got %h expected fe", joy1); end
      end
      wait_scan();
    end
  endtask

  task automatic test_coin;
    logic seen;
    jcoin = 2'b00;
    tick();
    checks++; if (coin_pulse !== 2'b00) begin errors++; $display("FAIL coin_c1: got %b expected 00", coin_pulse); end
    tick();
    checks++; if (coin_pulse !== 2'b00) begin errors++; $display("FAIL coin_c2: got %b expected 00", coin_pulse); end
    tick();
    checks++; if (coin_pulse !== 2'b11) begin errors++; $display("FAIL coin_c3: got %b expected 11", coin_pulse); end
    tick();
    checks++; if (coin_pulse !== 2'b00) begin errors++; $display("FAIL coin_c4: got %b expected 00", coin_pulse); end
    seen = 1'b0;
    repeat (6) begin tick(); if (coin_pulse !== 2'b00) seen = 1'b1; end
    jcoin = 2'b11;
    repeat (6) begin tick(); if (coin_pulse !== 2'b00) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL coin_hold_release: got extra pulse expected none"); end
    jcoin = 2'b10;
    repeat (3) tick();
    checks++; if (coin_pulse !== 2'b01) begin errors++; $display("FAIL coin_single: got %b expected 01", coin_pulse); end
    jcoin = 2'b11;
    repeat (6) tick();
  endtask

  task automatic test_reset_midscan;
    logic seen_sd, seen_coin;
    int   sd_at;
    logic [7:0] joy2_pre;
    wait_scan();
    repeat (20) tick();
    checks++; if (jselect !== 1'b1) begin errors++; $display("FAIL mid_in_s2: got jselect %b expected 1", jselect); end
    #2;
    rst_n = 1'b0;
    jcoin = 2'b00;
    #1;
    checks++; if (joy1 !== 8'hFF || joy2 !== 8'hFF) begin errors++; $display("FAIL mid_async_joy: got %h/%h expected ff/ff", joy1, joy2); end
    checks++; if (jselect !== 1'b0) begin errors++; $display("FAIL mid_async_jselect: got %b expected 0", jselect); end
    seen_sd = 1'b0;
    repeat (20) begin tick(); if (scan_done) seen_sd = 1'b1; end
    checks++; if (seen_sd) begin errors++; $display("FAIL mid_scan_done_in_rst: got pulse expected none"); end
    rst_n = 1'b1;
    sd_at = 0; seen_coin = 1'b0; joy2_pre = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (scan_done && sd_at == 0) sd_at = i;
      if (coin_pulse !== 2'b00) seen_coin = 1'b1;
      if (i == 33) joy2_pre = joy2;
    end
    checks++; if (sd_at != 34) begin errors++; $display("FAIL mid_restart: scan_done at cycle %0d expected 34", sd_at); end
    checks++; if (joy2_pre !== 8'hFF) begin errors++; $display("FAIL mid_joy2_idle: got %h expected ff", joy2_pre); end
    checks++; if (seen_coin) begin errors++; $display("FAIL mid_coin_held: got pulse expected none"); end
    jcoin = 2'b11;
    repeat (5) tick();
    jcoin = 2'b00;
    repeat (3) tick();
    checks++; if (coin_pulse !== 2'b11) begin errors++; $display("FAIL mid_coin_repress: got %b expected 11", coin_pulse); end
    jcoin = 2'b11;
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
`ifdef JAMMA_DEBOUNCE_EN
    test_debounce();
`else
    test_mux();
`endif
    test_coin();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
